// File: rtl/orthosis_if.sv
// Sensor/alarm inputs and actuator/state outputs of the orthosis supervisor.
// The master side drives sense and ppg; the slave side is the supervisor.
interface orthosis_if #(
    parameter int N_SENSE = 5
);
    logic [N_SENSE-1:0] sense;
    logic               ppg;
    logic               servo;
    logic               vib;
    logic               pump;
    logic               led;
    logic               heat;
    logic               ems;
    logic [1:0]         state;

    modport master (
        output sense, ppg,
        input  servo, vib, pump, led, heat, ems, state
    );

    modport slave (
        input  sense, ppg,
        output servo, vib, pump, led, heat, ems, state
    );
endinterface

// File: rtl/orthosis_supervisor.sv
// Orthosis supervisor: debounced motion sensors select actuators, ppg alarm forces SAFETY.
// Define ORTHOSIS_EMS_LIMIT_EN to enable EMS on-time limiting with a COOLDOWN lockout state.
module orthosis_supervisor #(
    parameter int                 N_SENSE      = 5,
    parameter int                 DEB_CYC      = 4,
    parameter int                 EMS_MIN      = 3,
    parameter logic [N_SENSE-1:0] SERVO_MASK   = 5'b10001,
    parameter logic [N_SENSE-1:0] PUMP_MASK    = 5'b00100,
    parameter logic [N_SENSE-1:0] HEAT_MASK    = 5'b01000,
    parameter int                 EMS_MAX_ON   = 100,
    parameter int                 COOLDOWN_CYC = 50,
    parameter int                 SAFE_HOLD    = 16
) (
    input logic       clk,
    input logic       reset,
    orthosis_if.slave bus
);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int CW = $clog2(N_SENSE + 1);
    localparam int HW = $clog2(SAFE_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        SAFETY   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [N_SENSE-1:0] filt;
    logic [DW-1:0]      deb_cnt [N_SENSE];
    logic               ppg_q;
    logic [HW-1:0]      hold_cnt, hold_d;
    logic [CW-1:0]      cnt;
    logic               ems_req;
    logic               servo_q, vib_q, pump_q, led_q, heat_q, ems_q;
    logic               servo_d, vib_d, pump_d, led_d, heat_d, ems_d;

`ifdef ORTHOSIS_EMS_LIMIT_EN
    localparam int EW  = $clog2(EMS_MAX_ON + 1);
    localparam int CDW = $clog2(COOLDOWN_CYC + 1);
    logic [EW-1:0]  ems_on, ems_on_d;
    logic [CDW-1:0] cool_cnt, cool_d;
    logic           timeout;
`else
    logic unused_cfg;
    assign unused_cfg = ^{EMS_MAX_ON, COOLDOWN_CYC};
`endif

    // A filtered bit flips only after the raw bit disagrees with it for DEB_CYC straight edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= '0;
            for (int i = 0; i < N_SENSE; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_SENSE; i++) begin
                if (bus.sense[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
                    filt[i]    <= ~filt[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N_SENSE; i++) cnt = cnt + CW'(filt[i]);
    end

    assign ems_req = (cnt >= CW'(EMS_MIN));

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
`ifdef ORTHOSIS_EMS_LIMIT_EN
        cool_d   = '0;
        ems_on_d = '0;
        timeout  = (state_q == ACTIVE) && ems_q && (ems_on == EW'(EMS_MAX_ON - 1));
`endif
        case (state_q)
            IDLE: begin
                if (filt != '0) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (filt == '0) state_d = IDLE;
`ifdef ORTHOSIS_EMS_LIMIT_EN
                else if (timeout) state_d = COOLDOWN;
`endif
            end
            SAFETY: begin
                if (hold_cnt == HW'(SAFE_HOLD - 1)) state_d = IDLE;
                else hold_d = hold_cnt + 1'b1;
            end
`ifdef ORTHOSIS_EMS_LIMIT_EN
            COOLDOWN: begin
                if (cool_cnt == CDW'(COOLDOWN_CYC - 1)) state_d = (filt != '0) ? ACTIVE : IDLE;
                else cool_d = cool_cnt + 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase

        // The alarm overrides everything and restarts every timer.
        if (ppg_q) begin
            state_d = SAFETY;
            hold_d  = '0;
`ifdef ORTHOSIS_EMS_LIMIT_EN
            cool_d  = '0;
`endif
        end

`ifdef ORTHOSIS_EMS_LIMIT_EN
        if (state_d == ACTIVE && ems_req)
            ems_on_d = (state_q == ACTIVE && ems_q) ? ems_on + 1'b1 : '0;
`endif

        servo_d = 1'b0;
        vib_d   = 1'b0;
        pump_d  = 1'b0;
        led_d   = 1'b0;
        heat_d  = 1'b0;
        ems_d   = 1'b0;
        case (state_d)
            ACTIVE, COOLDOWN: begin
                vib_d   = 1'b1;
                led_d   = 1'b1;
                servo_d = |(filt & SERVO_MASK);
                pump_d  = |(filt & PUMP_MASK);
                heat_d  = |(filt & HEAT_MASK);
                ems_d   = (state_d == ACTIVE) && ems_req;
            end
            SAFETY: begin
                heat_d = 1'b1;
                vib_d  = 1'b1;
                led_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ppg_q    <= 1'b0;
            hold_cnt <= '0;
            servo_q  <= 1'b0;
            vib_q    <= 1'b0;
            pump_q   <= 1'b0;
            led_q    <= 1'b0;
            heat_q   <= 1'b0;
            ems_q    <= 1'b0;
`ifdef ORTHOSIS_EMS_LIMIT_EN
            ems_on   <= '0;
            cool_cnt <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ppg_q    <= bus.ppg;
            hold_cnt <= hold_d;
            servo_q  <= servo_d;
            vib_q    <= vib_d;
            pump_q   <= pump_d;
            led_q    <= led_d;
            heat_q   <= heat_d;
            ems_q    <= ems_d;
`ifdef ORTHOSIS_EMS_LIMIT_EN
            ems_on   <= ems_on_d;
            cool_cnt <= cool_d;
`endif
        end
    end

    assign bus.state = state_q;
    assign bus.servo = servo_q;
    assign bus.vib   = vib_q;
    assign bus.pump  = pump_q;
    assign bus.led   = led_q;
    assign bus.heat  = heat_q;
    assign bus.ems   = ems_q;
endmodule

// File: doc/orthosis_supervisor.md
ORTHOSIS_SUPERVISOR -- requirements
Module: orthosis_supervisor

Interface
REQ-001 Parameter N_SENSE, 5, number of motion-sensor channels (1..16); bit0 IMU, 1 Accel, 2 FSR, 3 EMG, 4 Flex at default.
REQ-002 Parameter DEB_CYC, 4, consecutive cycles a raw sensor bit must differ from its filtered value before the filtered value flips (>=1).
REQ-003 Parameter EMS_MIN, 3, minimum count of filtered-high channels that enables EMS (1..N_SENSE).
REQ-004 Parameter SERVO_MASK, 5'b10001; PUMP_MASK, 5'b00100; HEAT_MASK, 5'b01000: N_SENSE-bit channel masks driving servo, pump and heat.
REQ-005 Parameter EMS_MAX_ON, 100, maximum continuous EMS-on cycles; COOLDOWN_CYC, 50, EMS lockout length (used only under REQ-031).
REQ-006 Parameter SAFE_HOLD, 16, consecutive ppg-low cycles required to leave SAFETY.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 sense  input  N_SENSE  raw motion-sensor flags.
REQ-010 ppg  input  1  physiological alarm; 1 = unsafe.
REQ-011 servo, vib, pump, led, heat, ems  output  1 each  registered actuator enables.
REQ-012 state  output  2  current state: 0 IDLE, 1 ACTIVE, 2 SAFETY, 3 COOLDOWN.

Function
REQ-013 Each sense bit has an independent debounce counter; filt[i] toggles on the edge on which raw != filt[i] has held for DEB_CYC consecutive edges; any cycle with raw == filt[i] clears that counter.
REQ-014 ppg is registered once (ppg_q), not debounced.
REQ-015 cnt = popcount(filt), width $clog2(N_SENSE+1), no overflow possible.
REQ-016 State, counters and all outputs update on the same edge from (state, filt, ppg_q); outputs are a registered decode of the next state.
REQ-017 Transition priority, every state: ppg_q=1 -> SAFETY; else per REQ-018..021.
REQ-018 IDLE: filt != 0 -> ACTIVE; else stay. Outputs all 0.
REQ-019 ACTIVE: filt == 0 -> IDLE; else EMS timeout (REQ-031) -> COOLDOWN; else stay.
REQ-020 ACTIVE outputs: vib=led=1; servo=|(filt&SERVO_MASK); pump=|(filt&PUMP_MASK); heat=|(filt&HEAT_MASK); ems=(cnt>=EMS_MIN).
REQ-021 SAFETY: outputs heat=vib=led=1, servo=pump=ems=0; hold counter increments while ppg_q=0, clears on ppg_q=1; reaching SAFE_HOLD -> IDLE.
REQ-022 Entering SAFETY clears the EMS-on and cooldown counters.
REQ-023 Latency: ppg rising before edge k -> SAFETY outputs after edge k+1; sense bit rising and held -> ACTIVE outputs after edge DEB_CYC+1.
REQ-024 filt clearing and EMS timeout on the same edge -> IDLE.
REQ-025 Debounce runs in every state, including SAFETY.

Reset
REQ-026 reset=1 on an edge forces state=IDLE, all outputs 0, filt=0, ppg_q=0, all counters 0, regardless of state or in-progress timers.
REQ-027 Reset dominates ppg and sense on the same edge; first post-reset evaluation occurs on the edge after reset deasserts.

Configuration
REQ-028 Macro ORTHOSIS_EMS_LIMIT_EN controls EMS on-time limiting.
REQ-029 Defined: ems_on counter increments each ACTIVE cycle with ems=1, clears when ems=0.
REQ-030 Defined: COOLDOWN state exists; outputs as ACTIVE but ems=0; lasts COOLDOWN_CYC cycles, then -> ACTIVE if filt != 0 else IDLE; filt==0 does not shorten it.
REQ-031 Defined: ems_on reaching EMS_MAX_ON is the EMS timeout; ems deasserts on that edge.
REQ-032 Undefined: no COOLDOWN, no ems_on counter, state never reads 3, ems follows REQ-020 indefinitely.

Verification
REQ-033 Defaults; after reset sense=5'b00111 held -> edge 5 state=1, servo=1, pump=1, vib=led=1, ems=1, heat=0.
REQ-034 sense bit0 pulse 3 cycles (< DEB_CYC) -> filt stays 0, state=0, all outputs 0.
REQ-035 In ACTIVE, ppg=1 one cycle -> 2 edges later state=2, heat=vib=led=1, others 0; exits to IDLE exactly 16 edges after ppg_q returns low; re-pulse at hold count 10 restarts count.
REQ-036 With ORTHOSIS_EMS_LIMIT_EN, sense=5'b11111 held -> ems=1 for exactly 100 cycles, state=3 for 50 cycles with ems=0, then state=1, ems=1; without macro ems stays 1 throughout.
REQ-037 reset asserted mid-COOLDOWN and mid-SAFETY -> next edge state=0, all outputs 0; sense held high re-enters ACTIVE after DEB_CYC+1 edges post-reset.
